// File: rtl/alu16_issue_ctrl_if.sv
// Handshake bundle for alu16_issue_ctrl.
// Carries the instruction channel (instr_valid/instr_ready/instr) and the
// result channel (res_valid/res_ready/res_data/res_flags/res_err).
// The master modport is the instruction source and result consumer.
// The slave modport is the issue controller.
interface alu16_issue_ctrl_if #(
    parameter int W = 16
);
    logic         instr_valid;
    logic         instr_ready;
    logic [15:0]  instr;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [2:0]   res_flags;
    logic         res_err;

    modport master (
        output instr_valid,
        output instr,
        output res_ready,
        input  instr_ready,
        input  res_valid,
        input  res_data,
        input  res_flags,
        input  res_err
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  res_ready,
        output instr_ready,
        output res_valid,
        output res_data,
        output res_flags,
        output res_err
    );
endinterface

// File: rtl/alu16_issue_ctrl.sv
// Sequential front end for the alu16 combinational ALU: 4x16 register file,
// one instruction in flight, IDLE -> EXEC -> RESP.
// Ports: clk, rst (sync, active-high); bus (slave handshake bundle);
// alu_a/alu_b/alu_sel drive alu16; alu_out/alu_zero/alu_carry/alu_neg
// come back from it.
module alu16_issue_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu16_issue_ctrl_if.slave bus,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_neg
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         ready;
    logic         accept;
    logic         resp;

    logic [W-1:0] rf [NREG];
    logic [1:0]   rd_q;
    logic [7:0]   imm_q;
    logic [W-1:0] data_q;
    logic [2:0]   flags_q;
    logic         err_q;

    logic         is_alu;
    logic         is_ldi;

    // alu_sel holds the latched opcode during EXEC
    assign is_alu = (alu_sel <= 4'd9);
    assign is_ldi = (alu_sel == 4'hF);

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        resp    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // held low while rst is asserted
                ready  = ~rst;
                accept = bus.instr_valid & ready;
                if (accept)
                    state_d = EXEC;
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                resp = 1'b1;
                if (bus.res_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            data_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                // operands captured here, so rd == rs sees old values
                alu_a   <= rf[bus.instr[9:8]];
                alu_b   <= rf[bus.instr[7:6]];
                alu_sel <= bus.instr[15:12];
                rd_q    <= bus.instr[11:10];
                imm_q   <= bus.instr[7:0];
            end
            if (state_q == EXEC) begin
                unique case (1'b1)
                    is_alu: begin
                        rf[rd_q] <= alu_out;
                        data_q   <= alu_out;
                        flags_q  <= {alu_zero, alu_carry, alu_neg};
                        err_q    <= 1'b0;
                    end
                    is_ldi: begin
                        rf[rd_q] <= {{(W-8){1'b0}}, imm_q};
                        data_q   <= {{(W-8){1'b0}}, imm_q};
                        err_q    <= 1'b0;
                    end
                    default: begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // res_valid is exactly "in RESP"; the state register carries it
    assign bus.instr_ready = ready;
    assign bus.res_valid   = resp;
    assign bus.res_data    = data_q;
    assign bus.res_flags   = flags_q;
    assign bus.res_err     = err_q;
endmodule

// File: tb/tb_alu16_issue_ctrl.sv
// Bench for alu16_issue_ctrl with a behavioural alu16 model.
// Directed instructions; expected responses go through a scoreboard queue.
module tb_alu16_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_neg;
    logic [16:0] t;

    always #5 clk = ~clk;

    alu16_issue_ctrl_if bus ();

    alu16_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_neg   (alu_neg)
    );

    always_comb begin
        t = '0;
        case (alu_sel)
            4'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2: t = {1'b0, alu_a & alu_b};
            4'd3: t = {1'b0, alu_a | alu_b};
            4'd4: t = {1'b0, alu_a ^ alu_b};
            4'd5: t = {1'b0, ~alu_a};
            4'd6: t = {alu_a, 1'b0};
            4'd7: t = {alu_a[0], 1'b0, alu_a[15:1]};
            4'd8: t = {16'd0, alu_a == alu_b};
            4'd9: t = {16'd0, alu_a > alu_b};
            default: t = '0;
        endcase
        alu_out   = t[15:0];
        alu_carry = t[16];
        alu_zero  = (t[15:0] == 16'd0);
        alu_neg   = t[15];
    end

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  f;
        logic        e;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op,
        input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd,
                                        input logic [7:0] imm);
        return {4'hF, rd, 2'b00, imm};
    endfunction

    task automatic monitor();
        resp_t snap;
        resp_t e;
        bit    held;
        held = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (bus.res_valid) begin
                chk("rdy_in_resp", 32'(bus.instr_ready), 0);
                if (held) begin
                    chk("hold_data", 32'(bus.res_data), 32'(snap.d));
                    chk("hold_flags", 32'(bus.res_flags), 32'(snap.f));
                    chk("hold_err", 32'(bus.res_err), 32'(snap.e));
                end
                if (bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual=%0h required=none",
                                 bus.res_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", 32'(bus.res_data), 32'(e.d));
                        chk("res_flags", 32'(bus.res_flags), 32'(e.f));
                        chk("res_err", 32'(bus.res_err), 32'(e.e));
                    end
                    held = 0;
                end else begin
                    held = 1;
                    snap = '{bus.res_data, bus.res_flags, bus.res_err};
                end
            end else begin
                held = 0;
            end
        end
    endtask

    // Waits for acceptance; returns #1 after the edge that accepted.
    task automatic offer(input logic [15:0] ins);
        int n;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d required=<20", n);
        end
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [15:0] d,
                         input logic [2:0] f, input logic e);
        exp_q.push_back('{d, f, e});
        offer(ins);
        @(negedge clk);
        chk("lat_exec", 32'(bus.res_valid), 0);
        @(negedge clk);
        chk("lat_resp", 32'(bus.res_valid), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rdy_in_rst", 32'(bus.instr_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_sel", 32'(alu_sel), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_res_data", 32'(bus.res_data), 0);
        chk("rst_res_err", 32'(bus.res_err), 0);
        chk("rst_flags", 32'(bus.res_flags), 0);
        chk("rst_rdy", 32'(bus.instr_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 32'(bus.instr_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.res_ready   = 1'b1;
        fork
            monitor();
        join_none

        do_reset();

        issue(ldi(2'd1, 8'hFF), 16'h00FF, 3'b000, 1'b0);
        issue(ldi(2'd2, 8'h01), 16'h0001, 3'b000, 1'b0);
        issue(enc(4'd0, 2'd3, 2'd1, 2'd2), 16'h0100, 3'b000, 1'b0);
        issue(enc(4'd5, 2'd0, 2'd0, 2'd0), 16'hFFFF, 3'b001, 1'b0);
        issue(enc(4'd0, 2'd0, 2'd0, 2'd2), 16'h0000, 3'b110, 1'b0);
        issue(enc(4'd1, 2'd3, 2'd2, 2'd1), 16'hFF02, 3'b011, 1'b0);
        issue(enc(4'hC, 2'd1, 2'd1, 2'd1), 16'h0000, 3'b011, 1'b1);
        issue(enc(4'd3, 2'd1, 2'd1, 2'd1), 16'h00FF, 3'b000, 1'b0);

        // backpressure with a competing instruction offered in RESP
        bus.res_ready = 1'b0;
        issue(enc(4'd4, 2'd2, 2'd1, 2'd2), 16'h00FE, 3'b000, 1'b0);
        bus.instr       = ldi(2'd2, 8'h55);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.res_valid), 1);
            chk("bp_rdy", 32'(bus.instr_ready), 0);
        end
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(enc(4'd3, 2'd3, 2'd2, 2'd2), 16'h00FE, 3'b000, 1'b0);

        do_reset();
        issue(enc(4'd0, 2'd0, 2'd1, 2'd2), 16'h0000, 3'b100, 1'b0);

        issue(ldi(2'd1, 8'h80), 16'h0080, 3'b100, 1'b0);
        issue(enc(4'd6, 2'd2, 2'd1, 2'd0), 16'h0100, 3'b000, 1'b0);
        issue(enc(4'd9, 2'd3, 2'd2, 2'd1), 16'h0001, 3'b000, 1'b0);
        issue(enc(4'd8, 2'd0, 2'd2, 2'd1), 16'h0000, 3'b100, 1'b0);
        issue(enc(4'd7, 2'd0, 2'd1, 2'd1), 16'h0040, 3'b000, 1'b0);

        // reset lands on the EXEC cycle of an ADD
        issue(ldi(2'd3, 8'h12), 16'h0012, 3'b000, 1'b0);
        offer(enc(4'd0, 2'd3, 2'd1, 2'd2));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("exec_rst_valid", 32'(bus.res_valid), 0);
        end
        @(posedge clk);
        #1;
        issue(enc(4'd3, 2'd3, 2'd3, 2'd3), 16'h0000, 3'b100, 1'b0);
        issue(enc(4'd3, 2'd1, 2'd1, 2'd1), 16'h0000, 3'b100, 1'b0);

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu16_issue_ctrl.md
Name: alu16_issue_ctrl

Overview:
Sequential front end for the 16-bit combinational ALU (alu16). It accepts encoded instructions over a valid/ready handshake and holds a 4x16 register file. It reads the source operands, drives the ALU's operand and select inputs, and captures the ALU result and flags. It writes the result back and returns it over a second valid/ready handshake. It issues one instruction at a time and has no pipelining.

Parameters:
NREG, 4, number of registers in the file; fixed at 4 because register index fields are 2 bits.
W, 16, datapath width; must match alu16.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  block can accept an instruction
instr  in  16  [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm8 (LOADI only)
alu_a  out  16  to alu16 A
alu_b  out  16  to alu16 B
alu_sel  out  4  to alu16 ALU_Sel
alu_out  in  16  from alu16 ALU_Out
alu_zero  in  1  from alu16 Zero
alu_carry  in  1  from alu16 Carry
alu_neg  in  1  from alu16 Negative
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  16  result value
res_flags  out  3  {zero, carry, negative} flag register
res_err  out  1  instruction was a reserved opcode

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. It is named rst and sampled on the rising edge of clk.
- Reset values:
  - FSM goes to IDLE.
  - All registers r0..r3 = 0.
  - Flag register = 3'b000.
  - alu_a, alu_b, alu_sel = 0.
  - res_valid = 0, res_data = 0, res_err = 0.
  - instr_ready = 0 in the reset cycle and 1 in the first cycle after rst deasserts.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch the decoded fields. Register alu_a = r[rs1], alu_b = r[rs2], alu_sel = op[3:0]. Go to EXEC.
  - EXEC: instr_ready = 0. alu16 evaluates combinationally from the registered inputs. At the end of the cycle:
    - ALU ops 0000-1001: r[rd] <= alu_out, res_data <= alu_out, flags <= {alu_zero, alu_carry, alu_neg}, res_err <= 0.
    - LOADI 1111: r[rd] <= {8'h00, imm8}, res_data <= the same value; flags unchanged; res_err <= 0.
    - Reserved 1010-1110: no register write, flags unchanged, res_data <= 0, res_err <= 1.
    - In every case set res_valid <= 1 and go to RESP.
  - RESP: res_valid = 1. res_data, res_flags and res_err are held stable. instr_ready = 0, and instr_valid is ignored. On res_ready: res_valid <= 0 and go to IDLE.
- Timing:
  - Handshake in cycle T gives res_valid high from T+2.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with res_ready already high).
- ALU opcode meanings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 NOT A, 0110 SHL1 A, 0111 SHR1 A.
  - 1000 EQ, 1001 GT (unsigned).
  - SUB carry is bit 16 of the 17-bit difference, so it is 1 on borrow.
- Hazards: rd may equal rs1 or rs2. Operands are latched at acceptance, so the old values are used and the write happens in EXEC. No forwarding is needed because only one instruction is in flight.
- r0 is a normal writable register, not hard-wired to zero.
- alu_a, alu_b and alu_sel hold their last values outside EXEC.
- Flags are read-only to instructions. They are visible only on res_flags.
- Reset in any state, including EXEC, takes priority:
  - No writeback of the in-flight instruction; the register file is cleared.
  - A pending res_valid is dropped.
- res_valid never deasserts without res_ready, except on rst.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream -> all outputs 0, instr_ready = 1 in the first cycle after release, registers read back 0 (ADD r0 = r1 + r2 returns 0x0000, flags 3'b100).
- LOADI and add: LOADI r1 = 0xFF, LOADI r2 = 0x01, ADD r3 = r1 + r2 -> res_data 0x0100, flags 3'b000, res_valid exactly 2 cycles after acceptance.
- Carry, zero and negative: NOT r0 = ~r0 -> 0xFFFF, flags 3'b001. Then ADD r0 = r0 + r2 -> 0x0000, flags 3'b110. Then SUB r3 = r2 - r1 (0x0001 - 0x00FF) -> 0xFF02, flags 3'b011.
- Backpressure: hold res_ready low for 5 cycles and pulse instr_valid with a different instruction -> res_valid stays high, res_data unchanged, instr_ready = 0, second instruction not accepted and has no register effect.
- Reserved opcode: op 1100, rd = r1 -> res_err = 1, res_data 0, flags unchanged, r1 unchanged on a later read (OR r1, r1).
- Reset in EXEC: issue ADD r3 and assert rst in the EXEC cycle -> no res_valid, r3 reads 0 after reset.
